simple_systolic_array: RTL and testbench



---
 rtl/simple_systolic_array.sv | 242 ++++++++++++++++++++++++
 tb/tb_simple_systolic_array.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_systolic_array.sv
// simple_systolic_array: output-stationary NxN systolic matrix multiplier (C = A*B).
// Latency: beat 0 sampled at edge 0, C rows valid after edges 3N-1 .. 4N-2 (one row/cycle).
// Backpressure: none; beats arriving during drain/output are dropped, consumer must take every row.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   matrix_a_in     column k of A, element i at [i*DATA_W +: DATA_W]
//   matrix_b_in     row k of B, element j at [j*DATA_W +: DATA_W]
//   valid_in        beat qualifier; a frame is N consecutive valid beats
//   matrix_c_out    one row of C, element j at [j*ACC_W +: ACC_W]; zero when not valid
//   valid_out       matrix_c_out carries a C row
// Option: define SYSTOLIC_SAT_EN to make the accumulators saturate instead of wrapping.
// N must be at least 2.
module simple_systolic_array #(
  parameter int N      = 3,
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*DATA_W-1:0] matrix_a_in,
  input  logic [N*DATA_W-1:0] matrix_b_in,
  input  logic                valid_in,
  output logic [N*ACC_W-1:0]  matrix_c_out,
  output logic                valid_out
);

  localparam int CNT_W  = $clog2(2 * N);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(2 * N - 1);
  localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_OUTPUT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;  // beat enters the skew registers
  logic start;   // beat 0 of a frame: clear the accumulators
  logic flush;   // frame aborted: discard everything in flight

  always_comb begin
    accept = valid_in && (state_q == ST_IDLE || state_q == ST_LOAD);
    start  = valid_in && (state_q == ST_IDLE);
    flush  = !valid_in && (state_q == ST_LOAD);
  end

  // Control FSM. The single counter is the beat index in LOAD, the drain
  // cycle in DRAIN and the row index in OUTPUT. DRAIN lasts 2N cycles so that
  // OUTPUT begins right after edge 3N-1, one cycle after the last MAC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          state_d = ST_LOAD;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_LOAD: begin
        if (!valid_in) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_BEAT) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          state_d = ST_OUTPUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_OUTPUT: begin
        if (cnt_q == LAST_ROW) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Edge feeds: zero whenever no beat is being accepted, so the skew slots
  // outside a frame carry zeros.
  logic [DATA_W-1:0] a_feed [N];
  logic [DATA_W-1:0] b_feed [N];
  logic [DATA_W-1:0] a_edge [N];
  logic [DATA_W-1:0] b_edge [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_feed[i] = accept ? matrix_a_in[i*DATA_W +: DATA_W] : '0;
      b_feed[i] = accept ? matrix_b_in[i*DATA_W +: DATA_W] : '0;
    end
  end

  // Skew chains: row i of A and column i of B pass through i+1 registers,
  // so PE(i,j) sees term k at edge k+i+j+1.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    logic [DATA_W-1:0] a_sk_q [gi+1];
    logic [DATA_W-1:0] a_sk_d [gi+1];
    logic [DATA_W-1:0] b_sk_q [gi+1];
    logic [DATA_W-1:0] b_sk_d [gi+1];

    always_comb begin
      a_sk_d = '{default: '0};
      b_sk_d = '{default: '0};
      if (!flush) begin
        a_sk_d[0] = a_feed[gi];
        b_sk_d[0] = b_feed[gi];
        for (int s = 1; s <= gi; s++) begin
          a_sk_d[s] = a_sk_q[s-1];
          b_sk_d[s] = b_sk_q[s-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        a_sk_q <= '{default: '0};
        b_sk_q <= '{default: '0};
      end else begin
        a_sk_q <= a_sk_d;
        b_sk_q <= b_sk_d;
      end
    end

    assign a_edge[gi] = a_sk_q[gi];
    assign b_edge[gi] = b_sk_q[gi];
  end

  // One multiply-accumulate step, wrapping or saturating.
  function automatic logic [ACC_W-1:0] mac_step(input logic [ACC_W-1:0]  acc,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [PROD_W-1:0] prod;
`ifdef SYSTOLIC_SAT_EN
    logic [ACC_W:0] sum;
`endif
    prod = PROD_W'(a) * PROD_W'(b);
`ifdef SYSTOLIC_SAT_EN
    sum      = {1'b0, acc} + (ACC_W+1)'(prod);
    mac_step = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    mac_step = acc + ACC_W'(prod);
`endif
  endfunction

  // PE grid. Forwarding registers exist only between PEs (N x N-1 for A,
  // N-1 x N for B); the last column/row has nothing downstream.
  logic [DATA_W-1:0] a_op     [N][N];
  logic [DATA_W-1:0] b_op     [N][N];
  logic [DATA_W-1:0] a_pipe_q [N][N-1];
  logic [DATA_W-1:0] a_pipe_d [N][N-1];
  logic [DATA_W-1:0] b_pipe_q [N-1][N];
  logic [DATA_W-1:0] b_pipe_d [N-1][N];
  logic [ACC_W-1:0]  acc_q    [N][N];
  logic [ACC_W-1:0]  acc_d    [N][N];

  always_comb begin
    a_op     = '{default: '0};
    b_op     = '{default: '0};
    a_pipe_d = '{default: '0};
    b_pipe_d = '{default: '0};
    acc_d    = '{default: '0};

    for (int i = 0; i < N; i++) begin
      a_op[i][0] = a_edge[i];
      b_op[0][i] = b_edge[i];
      for (int j = 1; j < N; j++) begin
        a_op[i][j] = a_pipe_q[i][j-1];
        b_op[j][i] = b_pipe_q[j-1][i];
      end
    end

    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N - 1; j++) begin
        a_pipe_d[i][j] = flush ? '0 : a_op[i][j];
        b_pipe_d[j][i] = flush ? '0 : b_op[j][i];
      end
    end

    // Pipes are all zero at beat 0 (idle or just flushed), so clearing here
    // loses no real term.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_d[i][j] = start ? '0 : mac_step(acc_q[i][j], a_op[i][j], b_op[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_pipe_q <= '{default: '0};
      b_pipe_q <= '{default: '0};
      acc_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_pipe_q <= a_pipe_d;
      b_pipe_q <= b_pipe_d;
      acc_q    <= acc_d;
    end
  end

  // Row mux: decoded from registered state, forced to zero outside OUTPUT.
  always_comb begin
    matrix_c_out = '0;
    valid_out    = 1'b0;
    if (state_q == ST_OUTPUT) begin
      valid_out = 1'b1;
      for (int r = 0; r < N; r++) begin
        if (cnt_q == CNT_W'(r)) begin
          for (int j = 0; j < N; j++) begin
            matrix_c_out[j*ACC_W +: ACC_W] = acc_q[r][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_simple_systolic_array.sv
module tb_simple_systolic_array;

  localparam int N    = 3;
  localparam int DW   = 4;
  localparam int AW   = 8;
  localparam int MAXC = 8192;

`ifdef SYSTOLIC_SAT_EN
  localparam logic [23:0] OVF_ROW = 24'hFFFFFF;
`else
  localparam logic [23:0] OVF_ROW = 24'hA3A3A3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] a_in;
  logic [11:0] b_in;
  logic        vin;
  logic [23:0] c_out;
  logic        vout;

  always #5 clk = ~clk;

  simple_systolic_array #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .matrix_a_in  (a_in),
    .matrix_b_in  (b_in),
    .valid_in     (vin),
    .matrix_c_out (c_out),
    .valid_out    (vout)
  );

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;

  // Expected outputs indexed by the edge after which they must be visible.
  bit        exp_vld [MAXC];
  bit [23:0] exp_dat [MAXC];

  // Frame-level reference model.
  bit        in_frame  = 1'b0;
  int        free_edge = 0;
  int        nb        = 0;
  int        t0m       = 0;
  bit [11:0] fa [N];
  bit [11:0] fb [N];

  function automatic void schedule(input int t0);
    bit [23:0] row;
    int        s;
    for (int r = 0; r < N; r++) begin
      row = '0;
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += int'(fa[k][r*DW +: DW]) * int'(fb[k][j*DW +: DW]);
`ifdef SYSTOLIC_SAT_EN
        if (s > 255) s = 255;
`else
        s = s % 256;
`endif
        row[j*AW +: AW] = 8'(s);
      end
      if (t0 + 3*N - 1 + r < MAXC) begin
        exp_vld[t0 + 3*N - 1 + r] = 1'b1;
        exp_dat[t0 + 3*N - 1 + r] = row;
      end
    end
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      in_frame  = 1'b0;
      free_edge = cyc + 1;
      for (int e = cyc; e < MAXC; e++) begin
        exp_vld[e] = 1'b0;
        exp_dat[e] = '0;
      end
    end else if (in_frame) begin
      if (vin) begin
        fa[nb] = a_in;
        fb[nb] = b_in;
        nb++;
        if (nb == N) begin
          schedule(t0m);
          in_frame  = 1'b0;
          free_edge = t0m + 4*N;
        end
      end else begin
        in_frame  = 1'b0;
        free_edge = cyc + 1;
      end
    end else if (vin && cyc >= free_edge) begin
      in_frame = 1'b1;
      nb       = 1;
      fa[0]    = a_in;
      fb[0]    = b_in;
      t0m      = cyc;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      vectors++;
      if (vout !== exp_vld[cyc] || c_out !== exp_dat[cyc]) begin
        miscompares++;
        $display("FAIL model_cmp edge %0d: got valid_out=%0b c=%06h, required valid_out=%0b c=%06h",
                 cyc, vout, c_out, exp_vld[cyc], exp_dat[cyc]);
      end
    end
  end

  task automatic check_lit(input string name, input bit v, input logic [23:0] d);
    vectors++;
    if (vout !== v || c_out !== d) begin
      miscompares++;
      $display("FAIL %s edge %0d: got valid_out=%0b c=%06h, required valid_out=%0b c=%06h",
               name, cyc, vout, c_out, v, d);
    end
  endtask

  // Returns at the falling edge following edge e.
  task automatic at_edge(input int e);
    int guard = 0;
    while (cyc < e && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != e) begin
      vectors++;
      miscompares++;
      $display("FAIL at_edge: reached edge %0d, required edge %0d", cyc, e);
    end
  endtask

  // Inputs change at the falling edge; the beat is sampled at edge cyc+1.
  task automatic drive(input logic [11:0] a, input logic [11:0] b, input logic v);
    a_in = a;
    b_in = b;
    vin  = v;
    @(negedge clk);
  endtask

  task automatic frame(input logic [11:0] a0, input logic [11:0] b0,
                       input logic [11:0] a1, input logic [11:0] b1,
                       input logic [11:0] a2, input logic [11:0] b2,
                       output int t0);
    t0 = cyc + 1;
    drive(a0, b0, 1'b1);
    drive(a1, b1, 1'b1);
    drive(a2, b2, 1'b1);
    drive(12'($urandom), 12'($urandom), 1'b0);
  endtask

  initial begin
    int t;
    int t2;
    int nbeats;

    rst  = 1'b1;
    vin  = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(negedge clk);
    check_lit("reset", 1'b0, 24'h000000);
    rst = 1'b0;
    repeat (3) drive(12'($urandom), 12'($urandom), 1'b0);
    check_lit("idle", 1'b0, 24'h000000);

    // Basic multiply
    frame(12'h741, 12'h789, 12'h852, 12'h456, 12'h963, 12'h123, t);
    at_edge(t + 7);  check_lit("basic_pre", 1'b0, 24'h000000);
    at_edge(t + 8);  check_lit("basic_row0", 1'b1, 24'h12181E);
    at_edge(t + 9);  check_lit("basic_row1", 1'b1, 24'h364554);
    at_edge(t + 10); check_lit("basic_row2", 1'b1, 24'h5A728A);
    at_edge(t + 11); check_lit("basic_post", 1'b0, 24'h000000);

    // Overflow, launched at the earliest accepted edge
    frame(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, t);
    at_edge(t + 8);  check_lit("ovf_row0", 1'b1, OVF_ROW);
    at_edge(t + 9);  check_lit("ovf_row1", 1'b1, OVF_ROW);
    at_edge(t + 10); check_lit("ovf_row2", 1'b1, OVF_ROW);
    at_edge(t + 11);

    // Aborted frame followed immediately by an identity-A frame
    drive(12'($urandom), 12'($urandom), 1'b1);
    drive(12'($urandom), 12'($urandom), 1'b1);
    drive(12'($urandom), 12'($urandom), 1'b0);
    frame(12'h001, 12'h789, 12'h010, 12'h456, 12'h100, 12'h123, t);
    at_edge(t + 5);  check_lit("abort_quiet", 1'b0, 24'h000000);
    at_edge(t + 8);  check_lit("ident_row0", 1'b1, 24'h070809);
    at_edge(t + 9);  check_lit("ident_row1", 1'b1, 24'h040506);
    at_edge(t + 10); check_lit("ident_row2", 1'b1, 24'h010203);
    at_edge(t + 11);

    // Second frame during drain is dropped; resending it later is clean
    frame(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
          12'($urandom), 12'($urandom), t);
    at_edge(t + 4);
    frame(12'h741, 12'h789, 12'h852, 12'h456, 12'h963, 12'h123, t2);
    at_edge(t + 11);
    frame(12'h741, 12'h789, 12'h852, 12'h456, 12'h963, 12'h123, t2);
    at_edge(t2 + 8);  check_lit("b2b_row0", 1'b1, 24'h12181E);
    at_edge(t2 + 9);  check_lit("b2b_row1", 1'b1, 24'h364554);
    at_edge(t2 + 10); check_lit("b2b_row2", 1'b1, 24'h5A728A);
    at_edge(t2 + 11);

    // Reset at edge 5 of a frame
    frame(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
          12'($urandom), 12'($urandom), t);
    at_edge(t + 4);
    rst = 1'b1;
    @(negedge clk);
    check_lit("rst_mid", 1'b0, 24'h000000);
    rst = 1'b0;
    at_edge(t + 8);  check_lit("rst_mid_r0", 1'b0, 24'h000000);
    at_edge(t + 10); check_lit("rst_mid_r2", 1'b0, 24'h000000);

    // Random traffic: gaps, aborts, overlap with busy periods, rare resets
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 4)) drive(12'($urandom), 12'($urandom), 1'b0);
      nbeats = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 3;
      for (int k = 0; k < nbeats; k++) drive(12'($urandom), 12'($urandom), 1'b1);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        drive(12'($urandom), 12'($urandom), 1'b0);
        rst = 1'b0;
      end
    end
    repeat (16) drive(12'($urandom), 12'($urandom), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
